regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port register file with write bypass and a load scoreboard.
//  Sits in the decode stage. Supplies NRD operands per cycle from flip-flop storage.
//  Two write ports: A is the ALU/execute result, B is the load/memory return.
//  Per-register pending bits mark outstanding loads, so issue logic can stall on busy operands.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   index width; 2**ADDR_W architectural indices
//  NRD       2   number of read ports (1..4)
//  PC_IDX    15  index whose reads return pc_if; it has no storage
//  BYPASS    1   1: same-cycle write data is forwarded to the read ports; 0: reads see storage only
//  RESET_VAL 0   reset value of every storage register
// PORTS
//  nGCLK     in   1            clock; all state changes on the rising edge
//  nRESET    in   1            asynchronous reset, active low
//  nWAIT     in   1            clock enable; 0 freezes all state
//  index     in   NRD*ADDR_W   read indices; port k uses bits [k*ADDR_W +: ADDR_W]
//  port      out  NRD*DATA_W   read data; port k uses bits [k*DATA_W +: DATA_W]
//  rd_busy   out  NRD          port k operand has a load pending
//  pc_if     in   DATA_W       PC value returned for PC_IDX
//  wena_a    in   1            write enable, port A
//  w_addr_a  in   ADDR_W       write index, port A
//  write_a   in   DATA_W       write data, port A
//  wena_b    in   1            write enable, port B
//  w_addr_b  in   ADDR_W       write index, port B
//  write_b   in   DATA_W       write data, port B
//  lock_ena  in   1            mark lock_addr as load-pending
//  lock_addr in   ADDR_W       index to mark pending
//  sb_err    out  1            sticky: port A wrote a pending register
// BEHAVIOUR
//  Index mapping
//   - MAXI = 2**ADDR_W-1. Effective index eff = (idx==MAXI) ? 0 : idx.
//   - This applies to reads, writes and the lock index.
//   - Storage exists for every eff except PC_IDX.
//  Writes
//   - Occur at posedge nGCLK when nWAIT=1.
//   - If both ports target the same eff, A wins and B's data is dropped.
//   - Writes to PC_IDX are ignored.
//  Reads (combinational)
//   - eff==PC_IDX -> pc_if.
//   - Else, if BYPASS=1 and nWAIT=1: wena_a and eff(w_addr_a)==eff -> write_a;
//     else wena_b and eff(w_addr_b)==eff -> write_b.
//   - Otherwise the storage value.
//  Scoreboard
//   - pend[i] updates at posedge when nWAIT=1.
//   - Cleared when wena_b writes i.
//   - Set when lock_ena and eff(lock_addr)==i. Set wins over a simultaneous clear.
//   - lock_addr==PC_IDX is ignored.
//   - Port A does not clear pend.
//  rd_busy[k]
//   - = pend[eff_k] & ~clr_k, where clr_k = BYPASS & nWAIT & wena_b & eff(w_addr_b)==eff_k.
//   - Always 0 for PC_IDX.
//  sb_err
//   - Set at posedge (nWAIT=1) when wena_a targets a register with pend=1.
//   - Cleared only by reset.
//  nWAIT=0
//   - Storage, pend and sb_err hold.
//   - Bypass is disabled: reads and rd_busy reflect stored state only.
//  Reset (asynchronous, any time, including mid-write)
//   - All storage = RESET_VAL, pend = 0, sb_err = 0.
//   - Outputs immediately show RESET_VAL (pc_if for PC_IDX) and rd_busy = 0.
//  Latency
//   - Read: 0 cycles. Write visible in storage next cycle; visible same cycle when BYPASS=1.
// TESTING
//  1. Reset -> every index reads 0, index 15 reads pc_if; rd_busy=0; sb_err=0.
//  2. wena_a=1, w_addr_a=3, 0xAAAA0001 with wena_b=1, w_addr_b=3, 0xBBBB0002
//     -> r3=0xAAAA0001; same-cycle read of 3 returns 0xAAAA0001 (BYPASS=1).
//  3. Write 0x55 to index 0, then read index 31 -> 0x55.
//     Write to index 15 -> ignored; reads still return pc_if.
//  4. lock 5; next cycle read 5 -> rd_busy=1.
//     wena_b to 5 with 0x1234 -> rd_busy=0 that cycle, port=0x1234, pend cleared.
//  5. nWAIT=0 with wena_a to 7 and lock 7 -> r7, pend[7] and sb_err unchanged; no bypass.
//  6. lock 9, then wena_a to 9 -> sb_err=1 next cycle.
//     Assert nRESET low mid-cycle -> sb_err=0 immediately, all registers 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with same-cycle write bypass and a load scoreboard.
// The all-ones index aliases index 0; PC_IDX has no storage and reads return pc_if.
module regfile_sb #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                NRD       = 2,
  parameter int                PC_IDX    = 15,
  parameter int                BYPASS    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  nGCLK,
  input  logic                  nRESET,
  input  logic                  nWAIT,
  input  logic [NRD*ADDR_W-1:0] index,
  output logic [NRD*DATA_W-1:0] port,
  output logic [NRD-1:0]        rd_busy,
  input  logic [DATA_W-1:0]     pc_if,
  input  logic                  wena_a,
  input  logic [ADDR_W-1:0]     w_addr_a,
  input  logic [DATA_W-1:0]     write_a,
  input  logic                  wena_b,
  input  logic [ADDR_W-1:0]     w_addr_b,
  input  logic [DATA_W-1:0]     write_b,
  input  logic                  lock_ena,
  input  logic [ADDR_W-1:0]     lock_addr,
  output logic                  sb_err
);

  localparam int                NREG   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] MAXI   = '1;
  localparam logic [ADDR_W-1:0] PC_EFF = ADDR_W'(PC_IDX);

  function automatic logic [ADDR_W-1:0] effIdx(input logic [ADDR_W-1:0] a);
    return (a == MAXI) ? '0 : a;
  endfunction

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_pend;
  logic              r_sbErr;

  logic [ADDR_W-1:0] w_effA;
  logic [ADDR_W-1:0] w_effB;
  logic [ADDR_W-1:0] w_effL;
  logic              w_wrA;
  logic              w_wrB;
  logic              w_lock;
  logic              w_bypassEn;

  assign w_effA     = effIdx(w_addr_a);
  assign w_effB     = effIdx(w_addr_b);
  assign w_effL     = effIdx(lock_addr);
  assign w_wrA      = wena_a && (w_effA != PC_EFF);
  // Port B loses a same-index collision with port A.
  assign w_wrB      = wena_b && (w_effB != PC_EFF) && !(wena_a && (w_effA == w_effB));
  assign w_lock     = lock_ena && (w_effL != PC_EFF);
  // Forwarding is suppressed while frozen or held in reset so reads show stored state only.
  assign w_bypassEn = (BYPASS != 0) && nWAIT && nRESET;

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (nWAIT) begin
      if (w_wrA) r_regs[w_effA] <= write_a;
      if (w_wrB) r_regs[w_effB] <= write_b;
    end
  end

  // The later set assignment overrides a same-cycle clear of the same entry.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_pend <= '0;
    end else if (nWAIT) begin
      if (wena_b) r_pend[w_effB] <= 1'b0;
      if (w_lock) r_pend[w_effL] <= 1'b1;
    end
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_sbErr <= 1'b0;
    end else if (nWAIT && wena_a && r_pend[w_effA]) begin
      r_sbErr <= 1'b1;
    end
  end

  assign sb_err = r_sbErr;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_eff;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    assign w_eff = effIdx(index[k*ADDR_W +: ADDR_W]);

    always_comb begin
      w_data = r_regs[w_eff];
      w_busy = r_pend[w_eff];
      if (w_eff == PC_EFF) begin
        w_data = pc_if;
        w_busy = 1'b0;
      end else begin
        if (w_bypassEn && wena_a && (w_effA == w_eff)) begin
          w_data = write_a;
        end else if (w_bypassEn && wena_b && (w_effB == w_eff)) begin
          w_data = write_b;
        end
        if (w_bypassEn && wena_b && (w_effB == w_eff)) begin
          w_busy = 1'b0;
        end
      end
    end

    assign port[k*DATA_W +: DATA_W] = w_data;
    assign rd_busy[k]               = w_busy;
  end

endmodule
